// File: rtl/press_event_pkg.sv
// Shared types and default constants for the press event decoder.
// Defaults assume the 25 MHz board clock.
package press_event_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_SECOND,
    SECOND_PRESSED
  } state_t;

  localparam int C_LONG_PRESS_25MHZ = 25000000;
  localparam int C_DOUBLE_GAP_25MHZ = 7500000;
  localparam int EVENT_CNT_W        = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/switch_edge_detect.sv
// Press/release edge detection on the already-synchronised debounced switch level.
module switch_edge_detect (
  input  logic i_Clk,
  input  logic i_Reset,
  input  logic i_Switch,
  output logic o_Rise,
  output logic o_Fall
);

  logic r_switch_prev_q;
  logic r_switch_prev_d;

  assign r_switch_prev_d = i_Switch;

  // Resetting to 0 makes a switch held through reset look like a fresh press.
  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_switch_prev_q <= 1'b0;
    end else begin
      r_switch_prev_q <= r_switch_prev_d;
    end
  end

  assign o_Rise = i_Switch & ~r_switch_prev_q;
  assign o_Fall = ~i_Switch & r_switch_prev_q;

endmodule

// File: rtl/press_event_decoder.sv
// Classifies debounced presses as short, long or double and emits one-cycle
// registered event pulses plus a wrapping event counter.
module press_event_decoder
  import press_event_pkg::*;
#(
  parameter int c_LONG_PRESS = C_LONG_PRESS_25MHZ,
  parameter int c_DOUBLE_GAP = C_DOUBLE_GAP_25MHZ
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  input  logic                   i_Switch,
  output logic                   o_Short,
  output logic                   o_Long,
  output logic                   o_Double,
  output logic                   o_Busy,
  output logic [EVENT_CNT_W-1:0] o_Event_Count
);

  localparam int TIMER_W = $clog2(max_int(c_LONG_PRESS, c_DOUBLE_GAP));
  localparam logic [TIMER_W-1:0] LONG_LAST = TIMER_W'(c_LONG_PRESS - 1);
  localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'(c_DOUBLE_GAP - 1);

  logic rise;
  logic fall;

  state_t                 state_q, state_d;
  logic [TIMER_W-1:0]     timer_q, timer_d;
  logic                   short_q, short_d;
  logic                   long_q, long_d;
  logic                   double_q, double_d;
  logic                   busy_q, busy_d;
  logic [EVENT_CNT_W-1:0] cnt_q, cnt_d;

  switch_edge_detect u_edge (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Switch (i_Switch),
    .o_Rise   (rise),
    .o_Fall   (fall)
  );

  // Every held state is entered with the switch high and WAIT_SECOND with it
  // low, so the edge flags are equivalent to the raw level checks there.
  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    short_d  = 1'b0;
    long_d   = 1'b0;
    double_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = PRESSED;
        end
      end
      PRESSED: begin
        if (fall) begin
          state_d = WAIT_SECOND;
        end else if (timer_q == LONG_LAST) begin
          long_d  = 1'b1;
          state_d = LONG_HELD;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      LONG_HELD: begin
        if (fall) begin
          state_d = IDLE;
        end
      end
      WAIT_SECOND: begin
        if (rise) begin
          state_d = SECOND_PRESSED;
        end else if (timer_q == GAP_LAST) begin
          short_d = 1'b1;
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      SECOND_PRESSED: begin
        if (fall) begin
          double_d = 1'b1;
          state_d  = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (state_d != state_q) begin
      timer_d = '0;
    end

    busy_d = (state_d != IDLE);
    cnt_d  = (short_d | long_d | double_d) ? cnt_q + EVENT_CNT_W'(1) : cnt_q;
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q  <= IDLE;
      timer_q  <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
      busy_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      timer_q  <= timer_d;
      short_q  <= short_d;
      long_q   <= long_d;
      double_q <= double_d;
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
    end
  end

  assign o_Short       = short_q;
  assign o_Long        = long_q;
  assign o_Double      = double_q;
  assign o_Busy        = busy_q;
  assign o_Event_Count = cnt_q;

endmodule

// File: tb/tb_press_event_decoder.sv
// Bench for press_event_decoder: directed and random press patterns checked
// every cycle against a timestamp-based reference model.
module tb_press_event_decoder;

  localparam int L = 8;
  localparam int G = 5;

  logic       clk;
  logic       i_Reset;
  logic       i_Switch;
  logic       o_Short;
  logic       o_Long;
  logic       o_Double;
  logic       o_Busy;
  logic [7:0] o_Event_Count;

  int checks = 0;
  int errors = 0;

  press_event_decoder #(.c_LONG_PRESS(L), .c_DOUBLE_GAP(G)) dut (
    .i_Clk         (clk),
    .i_Reset       (i_Reset),
    .i_Switch      (i_Switch),
    .o_Short       (o_Short),
    .o_Long        (o_Long),
    .o_Double      (o_Double),
    .o_Busy        (o_Busy),
    .o_Event_Count (o_Event_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: tracks when the current press / release began and
  // derives events from elapsed cycle counts.
  int   m_cyc = 0;
  bit   m_prev, m_busy, m_first, m_longheld, m_gap, m_second;
  int   m_t_start, m_t_rel;
  logic m_short, m_long, m_double;
  logic [7:0] m_cnt;

  // Observed-event bookkeeping for latency checks.
  int n_short = 0, n_long = 0, n_double = 0;
  int last_short_cyc = -1, last_long_cyc = -1, last_double_cyc = -1;

  function automatic void model_reset();
    m_prev = 0; m_busy = 0; m_first = 0; m_longheld = 0; m_gap = 0; m_second = 0;
    m_short = 0; m_long = 0; m_double = 0; m_cnt = 8'd0;
    m_t_start = 0; m_t_rel = 0;
  endfunction

  function automatic void model_step(input logic s);
    m_short = 0; m_long = 0; m_double = 0;
    m_cyc++;
    if (!m_busy) begin
      if (s && !m_prev) begin
        m_busy = 1; m_first = 1; m_t_start = m_cyc;
      end
    end else if (m_first) begin
      if (!s) begin
        m_first = 0; m_gap = 1; m_t_rel = m_cyc;
      end else if (m_cyc - m_t_start == L) begin
        m_long = 1; m_first = 0; m_longheld = 1;
      end
    end else if (m_longheld) begin
      if (!s) begin
        m_longheld = 0; m_busy = 0;
      end
    end else if (m_gap) begin
      if (s) begin
        m_gap = 0; m_second = 1;
      end else if (m_cyc - m_t_rel == G) begin
        m_short = 1; m_gap = 0; m_busy = 0;
      end
    end else if (m_second) begin
      if (!s) begin
        m_double = 1; m_second = 0; m_busy = 0;
      end
    end
    if (m_short || m_long || m_double) m_cnt = m_cnt + 8'd1;
    m_prev = s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d cycle=%0d", tag, obs, exp, m_cyc);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".short"},  {31'd0, o_Short},  {31'd0, m_short});
    chk({tag, ".long"},   {31'd0, o_Long},   {31'd0, m_long});
    chk({tag, ".double"}, {31'd0, o_Double}, {31'd0, m_double});
    chk({tag, ".busy"},   {31'd0, o_Busy},   {31'd0, m_busy});
    chk({tag, ".count"},  {24'd0, o_Event_Count}, {24'd0, m_cnt});
  endtask

  // Drive at the falling edge, let one rising edge sample it, check at the next falling edge.
  task automatic tick(input logic s, input string tag);
    i_Switch = s;
    @(posedge clk);
    model_step(s);
    @(negedge clk);
    check_all(tag);
    if (o_Short === 1'b1)  begin n_short++;  last_short_cyc  = m_cyc; end
    if (o_Long === 1'b1)   begin n_long++;   last_long_cyc   = m_cyc; end
    if (o_Double === 1'b1) begin n_double++; last_double_cyc = m_cyc; end
  endtask

  task automatic ticks(input logic s, input int n, input string tag);
    for (int i = 0; i < n; i++) tick(s, tag);
  endtask

  task automatic async_reset(input logic s, input string tag);
    i_Switch = s;
    i_Reset  = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    @(posedge clk);
    @(negedge clk);
    i_Reset = 1'b0;
  endtask

  int press_cyc, rel_cyc, s0, l0, d0;

  initial begin
    i_Reset  = 1'b1;
    i_Switch = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_all("reset");
    i_Reset = 1'b0;
    ticks(1'b0, 3, "idle");

    // Async reset with a random switch level, mid-cycle.
    async_reset(1'($urandom_range(0, 1)), "async_rst");
    ticks(1'b0, 2, "post_rst");

    // Short press.
    s0 = n_short;
    tick(1'b1, "short"); press_cyc = m_cyc;
    ticks(1'b1, 2, "short");
    tick(1'b0, "short"); rel_cyc = m_cyc;
    ticks(1'b0, 10, "short");
    chk("short.pulses", n_short - s0, 1);
    chk("short.latency", last_short_cyc - rel_cyc, G);
    chk("short.total", {24'd0, o_Event_Count}, 1);

    // Long press.
    l0 = n_long;
    tick(1'b1, "long"); press_cyc = m_cyc;
    ticks(1'b1, 19, "long");
    ticks(1'b0, 8, "long");
    chk("long.pulses", n_long - l0, 1);
    chk("long.latency", last_long_cyc - press_cyc, L);
    chk("long.total", {24'd0, o_Event_Count}, 2);

    // Double press.
    s0 = n_short; d0 = n_double;
    ticks(1'b1, 2, "double");
    ticks(1'b0, 3, "double");
    ticks(1'b1, 2, "double");
    tick(1'b0, "double"); rel_cyc = m_cyc;
    ticks(1'b0, 8, "double");
    chk("double.pulses", n_double - d0, 1);
    chk("double.latency", last_double_cyc - rel_cyc, 0);
    chk("double.no_short", n_short - s0, 0);

    // Release exactly when the hold timer reaches L-1: short, not long.
    s0 = n_short; l0 = n_long;
    ticks(1'b1, L, "bnd_rel");
    ticks(1'b0, 8, "bnd_rel");
    chk("bnd_rel.short", n_short - s0, 1);
    chk("bnd_rel.no_long", n_long - l0, 0);

    // Second press exactly when the gap timer reaches G-1: double, not short.
    s0 = n_short; d0 = n_double;
    ticks(1'b1, 2, "bnd_gap");
    ticks(1'b0, G, "bnd_gap");
    ticks(1'b1, 2, "bnd_gap");
    ticks(1'b0, 8, "bnd_gap");
    chk("bnd_gap.double", n_double - d0, 1);
    chk("bnd_gap.no_short", n_short - s0, 0);

    // Random press patterns.
    for (int e = 0; e < 40; e++) begin
      ticks(1'b1, $urandom_range(1, 12), "rand");
      ticks(1'b0, $urandom_range(1, 8), "rand");
    end
    ticks(1'b0, 8, "rand_tail");

    // Reset while PRESSED with the switch held; the held level re-triggers after reset.
    ticks(1'b1, 3, "mid_rst");
    async_reset(1'b1, "mid_rst_clear");
    l0 = n_long;
    tick(1'b1, "mid_rst_long"); press_cyc = m_cyc;
    ticks(1'b1, 11, "mid_rst_long");
    ticks(1'b0, 3, "mid_rst_long");
    chk("mid_rst.long_pulses", n_long - l0, 1);
    chk("mid_rst.long_latency", last_long_cyc - press_cyc, L);
    chk("mid_rst.total", {24'd0, o_Event_Count}, 1);

    // 256 short presses wrap the counter back to zero.
    async_reset(1'b0, "wrap_rst");
    s0 = n_short;
    for (int k = 0; k < 256; k++) begin
      tick(1'b1, "wrap");
      ticks(1'b0, G + 1, "wrap");
    end
    chk("wrap.pulses", n_short - s0, 256);
    chk("wrap.count", {24'd0, o_Event_Count}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
